// File: rtl/rename_walk_ctrl.sv
// rtl/rename_walk_ctrl.sv - freelist recovery sequencer: per-group allocation log walked youngest-first on redirect
// Pointers carry a wrap bit so full/empty and distances work modulo 2*DEPTH.
module rename_walk_ctrl #(
  parameter int DEPTH       = 32,
  parameter int FETCH_WIDTH = 4,
  parameter int GID_WIDTH   = $clog2(DEPTH),
  parameter int NUM_WIDTH   = $clog2(FETCH_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [NUM_WIDTH-1:0] alloc_num,
  output logic                 alloc_ready,
  output logic [GID_WIDTH-1:0] alloc_gid,
  input  logic                 retire_valid,
  input  logic                 redirect_valid,
  input  logic [GID_WIDTH-1:0] redirect_gid,
  output logic                 walk,
  output logic [NUM_WIDTH-1:0] walk_num,
  output logic                 walk_busy,
  output logic [GID_WIDTH:0]   group_count
);

  typedef enum logic {IDLE, WALK} state_t;

  localparam logic [GID_WIDTH:0] PTR_ONE = {{GID_WIDTH{1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [GID_WIDTH:0]   head, tail, walk_ptr, stop;
  logic [NUM_WIDTH-1:0] log_mem [DEPTH];
  logic                 walk_q;
  logic [NUM_WIDTH-1:0] walk_num_q;

  logic                 full, empty, alloc_fire, flush, step, in_range;
  logic [GID_WIDTH:0]   red_ptr, target, cur_ptr, eff_stop, sel_ptr;
  logic [NUM_WIDTH-1:0] sel_num;

  // Redirect gid takes the wrap bit of its logical position relative to head.
  always_comb begin
    empty      = (head == tail);
    full       = (head[GID_WIDTH-1:0] == tail[GID_WIDTH-1:0]) && (head[GID_WIDTH] != tail[GID_WIDTH]);
    red_ptr    = {(redirect_gid >= head[GID_WIDTH-1:0]) ? head[GID_WIDTH] : ~head[GID_WIDTH], redirect_gid};
    target     = red_ptr + PTR_ONE;
    in_range   = (red_ptr - head) < (tail - head);
    cur_ptr    = (state == WALK) ? walk_ptr : tail;
    flush      = redirect_valid && (target != cur_ptr);
    eff_stop   = flush ? target : stop;
    step       = ((state == WALK) || flush) && (cur_ptr != eff_stop);
    sel_ptr    = cur_ptr - PTR_ONE;
    sel_num    = log_mem[sel_ptr[GID_WIDTH-1:0]];
    alloc_fire = alloc_valid && alloc_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // WALK also covers the cycle showing the last registered pulse.
  always_comb begin
    state_n = state;
    if (step)                state_n = WALK;
    else if (state == WALK)  state_n = IDLE;
  end

  always_comb begin
    alloc_ready = !full && (state == IDLE) && !redirect_valid;
    alloc_gid   = tail[GID_WIDTH-1:0];
    walk_busy   = (state == WALK) || redirect_valid;
    group_count = tail - head;
    walk        = walk_q;
    walk_num    = walk_num_q;
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) log_mem[tail[GID_WIDTH-1:0]] <= alloc_num;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      walk_ptr   <= '0;
      stop       <= '0;
      walk_q     <= 1'b0;
      walk_num_q <= '0;
    end else begin
      if (retire_valid) head <= head + PTR_ONE;
      if (alloc_fire)   tail <= tail + PTR_ONE;
      if (flush)        stop <= target;
      if (step)         walk_ptr <= sel_ptr;
      walk_q     <= step && (sel_num != '0);
      walk_num_q <= step ? sel_num : '0;
      if ((state == WALK) && !step) tail <= eff_stop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && retire_valid) begin
      assert (!empty) else $error("retire_valid with empty group log");
    end
    if (!rst && redirect_valid) begin
      assert (in_range) else $error("redirect_gid outside live groups");
    end
  end

endmodule

// File: tb/tb_rename_walk_ctrl.sv
// tb/tb_rename_walk_ctrl.sv - directed self-checking bench for rename_walk_ctrl
module tb_rename_walk_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic [2:0] alloc_num;
  logic       alloc_ready;
  logic [4:0] alloc_gid;
  logic       retire_valid;
  logic       redirect_valid;
  logic [4:0] redirect_gid;
  logic       walk;
  logic [2:0] walk_num;
  logic       walk_busy;
  logic [5:0] group_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int total  = 0;

  rename_walk_ctrl dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_num(alloc_num), .alloc_ready(alloc_ready), .alloc_gid(alloc_gid),
    .retire_valid(retire_valid), .redirect_valid(redirect_valid), .redirect_gid(redirect_gid),
    .walk(walk), .walk_num(walk_num), .walk_busy(walk_busy), .group_count(group_count)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t5_num [4];
    logic       t5_walk [4];
    t5_num  = '{3'd2, 3'd3, 3'd1, 3'd0};
    t5_walk = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; alloc_valid = 1'b0; alloc_num = '0; retire_valid = 1'b0;
    redirect_valid = 1'b0; redirect_gid = '0;
    repeat (2) next();
    rst = 1'b0; #1;
    chk("rst_ready", alloc_ready, 1);
    chk("rst_gid", alloc_gid, 0);
    chk("rst_walk", walk, 0);
    chk("rst_walk_num", walk_num, 0);
    chk("rst_busy", walk_busy, 0);
    chk("rst_count", group_count, 0);

    // three groups: 2, 4, 1
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_num = (i == 0) ? 3'd2 : (i == 1) ? 3'd4 : 3'd1;
      #1;
      chk("t1_gid", alloc_gid, i);
      chk("t1_walk", walk, 0);
      next();
    end
    alloc_valid = 1'b0; #1;
    chk("t1_count", group_count, 3);
    chk("t1_next_gid", alloc_gid, 3);

    // flush gids 2,1
    redirect_valid = 1'b1; redirect_gid = 5'd0; #1;
    chk("t2_busy0", walk_busy, 1);
    chk("t2_ready0", alloc_ready, 0);
    chk("t2_walk0", walk, 0);
    next();
    redirect_valid = 1'b0; #1;
    chk("t2_walk1", walk, 1);
    chk("t2_num1", walk_num, 1);
    chk("t2_busy1", walk_busy, 1);
    next();
    chk("t2_walk2", walk, 1);
    chk("t2_num2", walk_num, 4);
    chk("t2_busy2", walk_busy, 1);
    next();
    chk("t2_busy3", walk_busy, 0);
    chk("t2_walk3", walk, 0);
    chk("t2_ready3", alloc_ready, 1);
    chk("t2_tail3", alloc_gid, 1);
    chk("t2_count3", group_count, 1);

    // redirect to youngest group: nothing flushed
    redirect_valid = 1'b1; redirect_gid = 5'd0; #1;
    chk("t3_busy0", walk_busy, 1);
    next();
    redirect_valid = 1'b0; #1;
    chk("t3_busy1", walk_busy, 0);
    chk("t3_walk1", walk, 0);
    chk("t3_tail", alloc_gid, 1);
    chk("t3_count", group_count, 1);

    // fill the log from a fresh reset, gid g logs g%5
    rst = 1'b1; next(); rst = 1'b0; #1;
    for (int g = 0; g < 32; g++) begin
      alloc_valid = 1'b1; alloc_num = 3'(g % 5); #1;
      chk("t4_fill_gid", alloc_gid, g);
      next();
    end
    alloc_num = 3'd4; #1;
    chk("t4_full_ready", alloc_ready, 0);
    chk("t4_full_count", group_count, 32);
    next();
    alloc_valid = 1'b0; #1;
    chk("t4_ignored_count", group_count, 32);
    retire_valid = 1'b1; #1;
    chk("t4_ready_retire_cycle", alloc_ready, 0);
    next();
    retire_valid = 1'b0; #1;
    chk("t4_ready_after", alloc_ready, 1);
    chk("t4_count_after", group_count, 31);
    chk("t4_wrap_gid", alloc_gid, 0);
    alloc_valid = 1'b1; alloc_num = 3'd3; #1;
    next();
    alloc_valid = 1'b0;

    // live gids 28..1 with tail wrapped to index 2
    retire_valid = 1'b1;
    repeat (27) next();
    retire_valid = 1'b0; #1;
    chk("t5_count_pre", group_count, 5);
    alloc_valid = 1'b1; alloc_num = 3'd2; #1;
    chk("t5_gid1", alloc_gid, 1);
    next();
    alloc_valid = 1'b0; #1;
    chk("t5_count", group_count, 6);
    redirect_valid = 1'b1; redirect_gid = 5'd29; #1;
    chk("t5_busy0", walk_busy, 1);
    next();
    redirect_valid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next();
      chk("t5_walk", walk, t5_walk[k]);
      chk("t5_walk_num", walk_num, t5_num[k]);
      chk("t5_busy", walk_busy, 1);
    end
    next();
    chk("t5_busy_end", walk_busy, 0);
    chk("t5_tail", alloc_gid, 30);
    chk("t5_count_end", group_count, 2);
    chk("t5_ready_end", alloc_ready, 1);

    // gids 30..1 logged 2,0,4,1; redirect to 31, then mid-walk to 29 with a retire
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_num = (i == 0) ? 3'd2 : (i == 1) ? 3'd0 : (i == 2) ? 3'd4 : 3'd1;
      #1;
      chk("t6_gid", alloc_gid, (30 + i) % 32);
      next();
    end
    alloc_valid = 1'b0; #1;
    chk("t6_count", group_count, 6);
    redirect_valid = 1'b1; redirect_gid = 5'd31; #1;
    chk("t6_busy0", walk_busy, 1);
    next();
    redirect_gid = 5'd29; retire_valid = 1'b1; #1;
    chk("t6_walk1", walk, 1);
    chk("t6_num1", walk_num, 1);
    total += walk_num;
    next();
    redirect_valid = 1'b0; retire_valid = 1'b0; #1;
    chk("t6_walk2", walk, 1);
    chk("t6_num2", walk_num, 4);
    total += walk_num;
    next();
    chk("t6_zero_walk", walk, 0);
    chk("t6_zero_busy", walk_busy, 1);
    total += walk_num;
    next();
    chk("t6_walk4", walk, 1);
    chk("t6_num4", walk_num, 2);
    total += walk_num;
    next();
    chk("t6_busy_end", walk_busy, 0);
    chk("t6_walk_end", walk, 0);
    chk("t6_tail", alloc_gid, 30);
    chk("t6_count_end", group_count, 1);
    chk("t6_total", total, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
